// File: rtl/csi2_pkt_parser.sv
// CSI-2 lane byte-stream packet parser: header, payload and CRC extraction. All outputs are registered
// (1-cycle latency) except reset_align_o. No backpressure; valid_i dropping mid-packet aborts the packet.
module csi2_pkt_parser #(
  parameter logic [15:0] WC_LIMIT = 16'd4096
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [7:0]  byte_i,
  output logic        reset_align_o,
  output logic        hdr_valid_o,
  output logic [1:0]  vc_o,
  output logic [5:0]  dt_o,
  output logic [15:0] wc_o,
  output logic [7:0]  ecc_o,
  output logic        short_pkt_o,
  output logic [7:0]  data_o,
  output logic        data_valid_o,
  output logic        data_last_o,
  output logic [15:0] crc_o,
  output logic        crc_valid_o,
  output logic        pkt_err_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PAYLOAD,
    S_CRC,
    S_END,
    S_DRAIN
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;
  logic [7:0]  r_di;
  logic [7:0]  r_wc_lo;
  logic [7:0]  r_wc_hi;
  logic [7:0]  r_crc_lo;
  logic        w_hdr_done;
  logic        w_beat;
  logic        w_crc_done;
  logic        w_err;
  logic [15:0] w_wc;
  logic        w_short;

  assign w_wc    = {r_wc_hi, r_wc_lo};
  assign w_short = (r_di[5:0] < 6'h10);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // r_cnt is the header byte index in HDR, the remaining payload bytes in PAYLOAD, the CRC byte index in CRC.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_hdr_done    = 1'b0;
    w_beat        = 1'b0;
    w_crc_done    = 1'b0;
    w_err         = 1'b0;
    reset_align_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (valid_i) begin
          w_state_nxt = S_HDR;
          w_cnt_nxt   = 16'd1;
        end
      end
      S_HDR: begin
        if (!valid_i) begin
          w_err       = 1'b1;
          w_state_nxt = S_END;
        end else if (r_cnt == 16'd3) begin
          w_hdr_done = 1'b1;
          if (w_short) begin
            w_state_nxt = S_END;
          end else if (w_wc == 16'd0) begin
            w_state_nxt = S_CRC;
            w_cnt_nxt   = 16'd0;
          end else if (w_wc > WC_LIMIT) begin
            w_err       = 1'b1;
            w_state_nxt = S_END;
          end else begin
            w_state_nxt = S_PAYLOAD;
            w_cnt_nxt   = w_wc;
          end
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_PAYLOAD: begin
        if (!valid_i) begin
          w_err       = 1'b1;
          w_state_nxt = S_END;
        end else begin
          w_beat    = 1'b1;
          w_cnt_nxt = r_cnt - 16'd1;
          if (r_cnt == 16'd1) begin
            w_state_nxt = S_CRC;
            w_cnt_nxt   = 16'd0;
          end
        end
      end
      S_CRC: begin
        if (!valid_i) begin
          w_err       = 1'b1;
          w_state_nxt = S_END;
        end else if (r_cnt == 16'd0) begin
          w_cnt_nxt = 16'd1;
        end else begin
          w_crc_done  = 1'b1;
          w_state_nxt = S_END;
        end
      end
      S_END: begin
        reset_align_o = 1'b1;
        w_state_nxt   = S_DRAIN;
      end
      S_DRAIN: begin
        if (!valid_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hdr_valid_o  <= 1'b0;
      short_pkt_o  <= 1'b0;
      data_valid_o <= 1'b0;
      data_last_o  <= 1'b0;
      crc_valid_o  <= 1'b0;
      pkt_err_o    <= 1'b0;
      vc_o         <= 2'd0;
      dt_o         <= 6'd0;
      wc_o         <= 16'd0;
      ecc_o        <= 8'd0;
      data_o       <= 8'd0;
      crc_o        <= 16'd0;
      r_di         <= 8'd0;
      r_wc_lo      <= 8'd0;
      r_wc_hi      <= 8'd0;
      r_crc_lo     <= 8'd0;
    end else begin
      hdr_valid_o  <= w_hdr_done;
      short_pkt_o  <= w_hdr_done & w_short;
      data_valid_o <= w_beat;
      data_last_o  <= w_beat && (r_cnt == 16'd1);
      crc_valid_o  <= w_crc_done;
      pkt_err_o    <= w_err;
      if (r_state == S_IDLE && valid_i) r_di <= byte_i;
      if (r_state == S_HDR && valid_i && r_cnt == 16'd1) r_wc_lo <= byte_i;
      if (r_state == S_HDR && valid_i && r_cnt == 16'd2) r_wc_hi <= byte_i;
      if (w_hdr_done) begin
        vc_o  <= r_di[7:6];
        dt_o  <= r_di[5:0];
        wc_o  <= w_wc;
        ecc_o <= byte_i;
      end
      if (w_beat) data_o <= byte_i;
      if (r_state == S_CRC && valid_i && r_cnt == 16'd0) r_crc_lo <= byte_i;
      if (w_crc_done) crc_o <= {byte_i, r_crc_lo};
    end
  end

endmodule

// File: tb/tb_csi2_pkt_parser.sv
// Bench for csi2_pkt_parser: packet-level timeline model checked every cycle, plus literal spot checks.
module tb_csi2_pkt_parser;
  localparam int N = 512;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vld = 1'b0;
  logic [7:0]  byt = 8'h00;
  logic        reset_align_o, hdr_valid_o, short_pkt_o, data_valid_o, data_last_o, crc_valid_o, pkt_err_o;
  logic [1:0]  vc_o;
  logic [5:0]  dt_o;
  logic [15:0] wc_o, crc_o;
  logic [7:0]  ecc_o, data_o;

  csi2_pkt_parser #(.WC_LIMIT(16'd4096)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(vld), .byte_i(byt),
    .reset_align_o(reset_align_o), .hdr_valid_o(hdr_valid_o),
    .vc_o(vc_o), .dt_o(dt_o), .wc_o(wc_o), .ecc_o(ecc_o), .short_pkt_o(short_pkt_o),
    .data_o(data_o), .data_valid_o(data_valid_o), .data_last_o(data_last_o),
    .crc_o(crc_o), .crc_valid_o(crc_valid_o), .pkt_err_o(pkt_err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;
  bit run = 1'b1;
  int n_dv = 0, n_last = 0, n_ra = 0, n_err = 0, n_hdr = 0;

  // expected output timeline, indexed by cycle
  logic        e_hdr[N], e_short[N], e_dv[N], e_last[N], e_crcv[N], e_err[N], e_ra[N];
  logic [1:0]  e_vc[N];
  logic [5:0]  e_dt[N];
  logic [15:0] e_wc[N], e_crc[N];
  logic [7:0]  e_ecc[N], e_dat[N];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
  endtask

  always @(negedge clk) begin
    if (run && cyc >= 1 && cyc < N) begin
      chk("hdr_valid", hdr_valid_o, e_hdr[cyc]);
      chk("short_pkt", short_pkt_o, e_short[cyc]);
      chk("data_valid", data_valid_o, e_dv[cyc]);
      chk("data_last", data_last_o, e_last[cyc]);
      chk("crc_valid", crc_valid_o, e_crcv[cyc]);
      chk("pkt_err", pkt_err_o, e_err[cyc]);
      chk("reset_align", reset_align_o, e_ra[cyc]);
      chk("vc", vc_o, e_vc[cyc]);
      chk("dt", dt_o, e_dt[cyc]);
      chk("wc", wc_o, e_wc[cyc]);
      chk("ecc", ecc_o, e_ecc[cyc]);
      chk("data", data_o, e_dat[cyc]);
      chk("crc", crc_o, e_crc[cyc]);
      n_dv   += int'(data_valid_o);
      n_last += int'(data_last_o);
      n_ra   += int'(reset_align_o);
      n_err  += int'(pkt_err_o);
      n_hdr  += int'(hdr_valid_o);
    end
  end

  task automatic clr_from(input int c);
    for (int k = c; k < N; k++) begin
      e_hdr[k] = 0; e_short[k] = 0; e_dv[k] = 0; e_last[k] = 0; e_crcv[k] = 0; e_err[k] = 0; e_ra[k] = 0;
      e_vc[k] = '0; e_dt[k] = '0; e_wc[k] = '0; e_crc[k] = '0; e_ecc[k] = '0; e_dat[k] = '0;
    end
  endtask

  task automatic set_hdr(input int c, input logic [7:0] di, input logic [15:0] wc, input logic [7:0] ecc);
    for (int k = c; k < N; k++) begin
      e_vc[k] = di[7:6]; e_dt[k] = di[5:0]; e_wc[k] = wc; e_ecc[k] = ecc;
    end
  endtask

  task automatic set_dat(input int c, input logic [7:0] d);
    for (int k = c; k < N; k++) e_dat[k] = d;
  endtask

  task automatic set_crc(input int c, input logic [15:0] v);
    for (int k = c; k < N; k++) e_crc[k] = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one packet starting this cycle; drop_q cuts the byte stream at that position
  // (valid_i low, or rst_i high when rst_cut), extra appends junk valid bytes after a full packet.
  task automatic send(input logic [7:0] di, input logic [15:0] wc, input logic [7:0] ecc,
                      input int drop_q, input bit rst_cut, input int extra,
                      input logic [7:0] crc_lo, input logic [7:0] crc_hi);
    int t0, len, qq;
    bit short_p, over, cut;
    logic [7:0] st[$];
    logic [7:0] pb;
    t0 = cyc;
    short_p = (di[5:0] < 6'h10);
    over = !short_p && (wc > 16'd4096);
    st = {di, wc[7:0], wc[15:8], ecc};
    if (!short_p && !over) begin
      for (int j = 0; j < int'(wc); j++) begin
        pb = 8'((j + 1) * 17);
        st.push_back(pb);
      end
      st.push_back(crc_lo);
      st.push_back(crc_hi);
    end
    len = st.size();
    cut = (drop_q >= 0) && (drop_q < len);
    qq = cut ? drop_q : len;
    if (qq >= 4) begin
      set_hdr(t0 + 4, di, wc, ecc);
      e_hdr[t0 + 4] = 1;
      e_short[t0 + 4] = short_p;
    end
    if (!short_p && !over) begin
      for (int j = 0; j < int'(wc); j++) begin
        if (4 + j < qq) begin
          e_dv[t0 + 5 + j] = 1;
          e_last[t0 + 5 + j] = (j == int'(wc) - 1);
          set_dat(t0 + 5 + j, st[4 + j]);
        end
      end
    end
    if (!cut) begin
      if (short_p) begin
        e_ra[t0 + 4] = 1;
      end else if (over) begin
        e_err[t0 + 4] = 1;
        e_ra[t0 + 4] = 1;
      end else begin
        e_crcv[t0 + 6 + int'(wc)] = 1;
        e_ra[t0 + 6 + int'(wc)] = 1;
        set_crc(t0 + 6 + int'(wc), {crc_hi, crc_lo});
      end
    end else if (rst_cut) begin
      clr_from(t0 + qq + 1);
    end else begin
      e_err[t0 + qq + 1] = 1;
      e_ra[t0 + qq + 1] = 1;
    end
    for (int p = 0; p < len; p++) begin
      if (cut && p == qq) begin
        rst = rst_cut;
        vld = 1'b0;
        byt = 8'h5A;
        tick();
        rst = 1'b0;
        break;
      end
      vld = 1'b1;
      byt = st[p];
      tick();
    end
    if (!cut) begin
      for (int e = 0; e < extra; e++) begin
        vld = 1'b1;
        byt = 8'hC3 ^ 8'(e);
        tick();
      end
    end
    for (int g = 0; g < 3; g++) begin
      vld = 1'b0;
      byt = 8'hE7;
      tick();
    end
  endtask

  int s_dv, s_last, s_ra, s_err, s_hdr;
  task automatic snap();
    s_dv = n_dv; s_last = n_last; s_ra = n_ra; s_err = n_err; s_hdr = n_hdr;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    clr_from(0);
    rst = 1'b1;
    tick(); tick(); tick();
    chk("rst_pulses", {reset_align_o, hdr_valid_o, short_pkt_o, data_valid_o, data_last_o, crc_valid_o, pkt_err_o}, 0);
    rst = 1'b0;
    tick(); tick();

    // short packet 00 05 00 xx, with junk valid bytes that DRAIN must ignore
    snap();
    send(8'h00, 16'h0005, 8'h3C, -1, 0, 3, 8'h00, 8'h00);
    chk("short_dt", dt_o, 6'h00);
    chk("short_wc", wc_o, 16'h0005);
    chk("short_hdr_cnt", n_hdr - s_hdr, 1);
    chk("short_dv_cnt", n_dv - s_dv, 0);
    chk("short_ra_cnt", n_ra - s_ra, 1);

    // long packet 2A 04 00 xx, payload 11 22 33 44, CRC CD AB
    snap();
    send(8'h2A, 16'h0004, 8'h77, -1, 0, 0, 8'hCD, 8'hAB);
    chk("long_dv_cnt", n_dv - s_dv, 4);
    chk("long_last_cnt", n_last - s_last, 1);
    chk("long_last_data", data_o, 8'h44);
    chk("long_crc", crc_o, 16'hABCD);
    chk("long_dt", dt_o, 6'h2A);

    // long packet with wc=0
    snap();
    send(8'h2B, 16'h0000, 8'h11, -1, 0, 0, 8'h01, 8'h02);
    chk("wc0_crc", crc_o, 16'h0201);
    chk("wc0_dv_cnt", n_dv - s_dv, 0);
    chk("wc0_ra_cnt", n_ra - s_ra, 1);

    // oversize word count, sender keeps streaming
    snap();
    send(8'h2C, 16'h2000, 8'h22, -1, 0, 5, 8'h00, 8'h00);
    chk("over_err_cnt", n_err - s_err, 1);
    chk("over_dv_cnt", n_dv - s_dv, 0);
    chk("over_ra_cnt", n_ra - s_ra, 1);
    chk("over_wc", wc_o, 16'h2000);

    snap();
    send(8'h2C, 16'h1001, 8'h23, -1, 0, 0, 8'h00, 8'h00);
    chk("over1_err_cnt", n_err - s_err, 1);

    // valid drops after payload byte 2 of 4, then a clean packet on VC1
    snap();
    send(8'h2D, 16'h0004, 8'h33, 6, 0, 0, 8'h00, 8'h00);
    chk("abort_dv_cnt", n_dv - s_dv, 2);
    chk("abort_last_cnt", n_last - s_last, 0);
    chk("abort_err_cnt", n_err - s_err, 1);
    snap();
    send(8'h6A, 16'h0004, 8'h44, -1, 0, 0, 8'h34, 8'h12);
    chk("post_abort_vc", vc_o, 2'd1);
    chk("post_abort_dv_cnt", n_dv - s_dv, 4);
    chk("post_abort_crc", crc_o, 16'h1234);

    // valid drops inside the header
    snap();
    send(8'h2E, 16'h0004, 8'h55, 2, 0, 0, 8'h00, 8'h00);
    chk("hdr_abort_hdr_cnt", n_hdr - s_hdr, 0);
    chk("hdr_abort_err_cnt", n_err - s_err, 1);

    // reset mid-payload, then a short packet
    snap();
    send(8'h2A, 16'h0008, 8'h66, 7, 1, 0, 8'h00, 8'h00);
    chk("rst_err_cnt", n_err - s_err, 0);
    chk("rst_dv_cnt", n_dv - s_dv, 3);
    chk("rst_wc_cleared", wc_o, 16'h0000);
    send(8'h81, 16'h1234, 8'h99, -1, 0, 0, 8'h00, 8'h00);
    chk("post_rst_vc", vc_o, 2'd2);
    chk("post_rst_dt", dt_o, 6'h01);
    chk("post_rst_wc", wc_o, 16'h1234);

    // single-byte payload: first beat is also the last
    snap();
    send(8'h12, 16'h0001, 8'h0F, -1, 0, 0, 8'hEF, 8'hBE);
    chk("wc1_dv_cnt", n_dv - s_dv, 1);
    chk("wc1_last_cnt", n_last - s_last, 1);
    chk("wc1_data", data_o, 8'h11);

    tick();
    run = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
